// File: rtl/pipe_inv_delay.sv
// Multi-channel clocked inverter/buffer delay line with a run-time selectable tap (1..MAX_DELAY).
// A change of effective delay flushes all in-flight words so no word is ever emitted at the wrong latency.
module pipe_inv_delay #(
  parameter int WIDTH     = 1,
  parameter int MAX_DELAY = 2,
  parameter int DLY_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] inv_mask,
  input  logic [DLY_W-1:0] dly,
  output logic             out_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dly_err
);

  localparam logic [DLY_W-1:0] MAX_D = DLY_W'(MAX_DELAY);

  // Clamp the requested delay into the legal 1..MAX_DELAY range.
  function automatic logic [DLY_W-1:0] eff_dly(input logic [DLY_W-1:0] req);
    if (req == '0)
      return DLY_W'(1);
    else if (req > MAX_D)
      return MAX_D;
    else
      return req;
  endfunction

  function automatic logic dly_bad(input logic [DLY_W-1:0] req);
    return (req == '0) || (req > MAX_D);
  endfunction

  logic [DLY_W-1:0]     dly_q;
  logic [DLY_W-1:0]     eff;
  logic                 flush;
  logic [MAX_DELAY-1:0] stg_v;
  logic [WIDTH-1:0]     stg_d [MAX_DELAY];
  logic [WIDTH-1:0]     tap_d;
  logic                 tap_v;

  assign eff   = eff_dly(dly);
  assign flush = (eff != dly_q);

  // Control: tap select, error flag and per-stage valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_q   <= MAX_D;
      dly_err <= 1'b0;
      stg_v   <= '0;
    end else begin
      dly_q   <= eff;
      dly_err <= dly_bad(dly);
      if (flush) begin
        stg_v <= '0;
      end else if (ce) begin
        for (int k = MAX_DELAY - 1; k > 0; k--)
          stg_v[k] <= stg_v[k-1];
        stg_v[0] <= in_valid;
      end
    end
  end

  // Data: inversion applied on entry, then a plain shift; contents are ignored while invalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MAX_DELAY; k++)
        stg_d[k] <= '0;
    end else if (ce && !flush) begin
      for (int k = MAX_DELAY - 1; k > 0; k--)
        stg_d[k] <= stg_d[k-1];
      stg_d[0] <= din ^ inv_mask;
    end
  end

  // Output tap: stage number dly_q lives at array index dly_q-1
  always_comb begin
    tap_v = 1'b0;
    tap_d = '0;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (dly_q == DLY_W'(k + 1)) begin
        tap_v = stg_v[k];
        tap_d = stg_d[k];
      end
    end
    out_valid = tap_v;
    dout      = tap_v ? tap_d : '0;
  end

endmodule

// File: tb/tb_pipe_inv_delay.sv
// Randomised and directed bench for pipe_inv_delay (WIDTH=4, MAX_DELAY=2) against a slot-history model.
module tb_pipe_inv_delay;

  localparam int W  = 4;
  localparam int MD = 2;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  din = '0;
  logic [W-1:0]  inv_mask = '0;
  logic [DW-1:0] dly = DW'(2);
  logic          out_valid;
  logic [W-1:0]  dout;
  logic          dly_err;

  int checks = 0;
  int errors = 0;

  pipe_inv_delay #(.WIDTH(W), .MAX_DELAY(MD), .DLY_W(DW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .din(din),
    .inv_mask(inv_mask), .dly(dly), .out_valid(out_valid), .dout(dout),
    .dly_err(dly_err)
  );

  always #5 clk = ~clk;

  // Reference: history of slots accepted since the last flush/reset, newest last.
  // The word visible on the output is the one accepted m_dlyq ce-edges ago.
  bit         mq_v[$];
  logic [W-1:0] mq_d[$];
  int         m_dlyq = MD;
  bit         m_err = 1'b0;
  int         m_eff;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq_v.delete();
      mq_d.delete();
      m_dlyq = MD;
      m_err  = 1'b0;
    end else begin
      m_eff = (dly == 0) ? 1 : ((int'(dly) > MD) ? MD : int'(dly));
      m_err = (dly == 0) || (int'(dly) > MD);
      if (m_eff != m_dlyq) begin
        mq_v.delete();
        mq_d.delete();
      end else if (ce) begin
        mq_v.push_back(in_valid);
        mq_d.push_back(din ^ inv_mask);
        if (mq_v.size() > MD) begin
          void'(mq_v.pop_front());
          void'(mq_d.pop_front());
        end
      end
      m_dlyq = m_eff;
    end
  end

  function automatic logic exp_v();
    if (mq_v.size() >= m_dlyq) return mq_v[mq_v.size() - m_dlyq];
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] exp_d();
    if (mq_v.size() >= m_dlyq && mq_v[mq_v.size() - m_dlyq]) return mq_d[mq_d.size() - m_dlyq];
    return '0;
  endfunction

  task automatic drive(input logic c, input logic iv, input logic [W-1:0] d,
                       input logic [W-1:0] m, input logic [DW-1:0] dl);
    ce = c; in_valid = iv; din = d; inv_mask = m; dly = dl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || dout !== '0 || dly_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b d=%h err=%0b exp v=0 d=0 err=0", out_valid, dout, dly_err);
    end
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_legacy();
    drive(1, 1, 4'hA, 4'hF, 2);
    tick();
    checks++;
    if (out_valid !== 1'b0 || dout !== 4'h0) begin
      errors++;
      $display("FAIL legacy_early got v=%0b d=%h exp v=0 d=0", out_valid, dout);
    end
    drive(1, 0, 4'h0, 4'hF, 2);
    tick();
    checks++;
    if (out_valid !== 1'b1 || dout !== 4'h5) begin
      errors++;
      $display("FAIL legacy_out got v=%0b d=%h exp v=1 d=5", out_valid, dout);
    end
  endtask

  task automatic test_dly1();
    drive(1, 0, 4'h0, 4'h0, 1);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL dly1_flush got v=%0b exp v=0", out_valid);
    end
    for (int k = 1; k <= 3; k++) begin
      drive(1, 1, W'(k), 4'h0, 1);
      tick();
      checks++;
      if (out_valid !== 1'b1 || dout !== W'(k)) begin
        errors++;
        $display("FAIL dly1_stream[%0d] got v=%0b d=%h exp v=1 d=%h", k, out_valid, dout, W'(k));
      end
    end
  endtask

  task automatic test_stall();
    drive(1, 0, 4'h0, 4'h0, 2);
    tick();
    drive(1, 1, 4'h3, 4'h0, 2);
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b0 || dout !== 4'h0) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%0b d=%h exp v=0 d=0", k, out_valid, dout);
      end
      if (k < 3) begin
        drive(0, 1, W'($urandom), 4'h0, 2);
        tick();
      end
    end
    drive(1, 0, 4'h0, 4'h0, 2);
    tick();
    checks++;
    if (out_valid !== 1'b1 || dout !== 4'h3) begin
      errors++;
      $display("FAIL stall_release got v=%0b d=%h exp v=1 d=3", out_valid, dout);
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] x;
    for (int k = 1; k <= 4; k++) begin
      drive(1, 1, W'($urandom), W'($urandom), 2);
      tick();
      checks++;
      if (out_valid !== exp_v() || dout !== exp_d()) begin
        errors++;
        $display("FAIL flush_pre[%0d] got v=%0b d=%h exp v=%0b d=%h", k, out_valid, dout, exp_v(), exp_d());
      end
    end
    drive(1, 1, W'($urandom), 4'h0, 1);
    tick();
    checks++;
    if (out_valid !== 1'b0 || dout !== 4'h0) begin
      errors++;
      $display("FAIL flush_edge got v=%0b d=%h exp v=0 d=0", out_valid, dout);
    end
    x = W'($urandom);
    drive(1, 1, x, 4'h0, 1);
    tick();
    checks++;
    if (out_valid !== 1'b1 || dout !== x) begin
      errors++;
      $display("FAIL flush_resume got v=%0b d=%h exp v=1 d=%h", out_valid, dout, x);
    end
  endtask

  task automatic test_err();
    logic [DW-1:0] req [3];
    logic          exp [3];
    req[0] = 2'd0; exp[0] = 1'b1;
    req[1] = 2'd3; exp[1] = 1'b1;
    req[2] = 2'd2; exp[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, W'($urandom), 4'h0, req[k]);
      tick();
      checks++;
      if (dly_err !== exp[k] || out_valid !== exp_v() || dout !== exp_d()) begin
        errors++;
        $display("FAIL dly_err[%0d] got err=%0b v=%0b d=%h exp err=%0b v=%0b d=%h",
                 k, dly_err, out_valid, dout, exp[k], exp_v(), exp_d());
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] dl;
    dl = 2'd2;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) dl = DW'($urandom_range(0, 3));
      drive(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0),
            W'($urandom), W'($urandom), dl);
      tick();
      checks++;
      if (out_valid !== exp_v() || dout !== exp_d() || dly_err !== m_err) begin
        errors++;
        $display("FAIL random[%0d] got v=%0b d=%h err=%0b exp v=%0b d=%h err=%0b",
                 k, out_valid, dout, dly_err, exp_v(), exp_d(), m_err);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] c;
    drive(1, 0, 4'h0, 4'h0, 2);
    tick();
    drive(1, 1, 4'h9, 4'h0, 2);
    tick();
    drive(1, 1, 4'h6, 4'h0, 2);
    tick();
    checks++;
    if (out_valid !== 1'b1 || dout !== 4'h9) begin
      errors++;
      $display("FAIL areset_inflight got v=%0b d=%h exp v=1 d=9", out_valid, dout);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || dout !== 4'h0 || dly_err !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate got v=%0b d=%h err=%0b exp v=0 d=0 err=0", out_valid, dout, dly_err);
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 4'h0, 4'h0, 2);
    tick();
    checks++;
    if (out_valid !== 1'b0 || dout !== 4'h0) begin
      errors++;
      $display("FAIL areset_stale got v=%0b d=%h exp v=0 d=0", out_valid, dout);
    end
    c = W'($urandom);
    drive(1, 1, c, 4'h0, 2);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_latency got v=%0b exp v=0", out_valid);
    end
    drive(1, 0, 4'h0, 4'h0, 2);
    tick();
    checks++;
    if (out_valid !== 1'b1 || dout !== c) begin
      errors++;
      $display("FAIL areset_resume got v=%0b d=%h exp v=1 d=%h", out_valid, dout, c);
    end
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_dly1();
    test_stall();
    test_flush();
    test_err();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_inv_delay.md
Name: pipe_inv_delay

Overview:
- Parametrised successor to the single-bit fixed-delay NOT primitive: a WIDTH-channel, clocked inverter/buffer with a run-time selectable delay of 1..MAX_DELAY cycles.
- Per-channel invert mask; valid tracking, clock-enable stall, and a flush on delay change.
- Used wherever the fixed gate delay must become a synthesizable, cycle-accurate delay line.

Parameters:
- WIDTH, 1, number of data channels.
- MAX_DELAY, 2, deepest selectable delay in cycles (>=1).
- DLY_W, 2, width of dly port; must satisfy 2**DLY_W > MAX_DELAY.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- ce  input  1  clock enable; low = pipeline holds.
- in_valid  input  1  din is valid this cycle.
- din  input  WIDTH  input data.
- inv_mask  input  WIDTH  bit k = 1 inverts channel k; sampled with din.
- dly  input  DLY_W  requested delay in cycles.
- out_valid  output  1  dout is valid.
- dout  output  WIDTH  delayed, optionally inverted data.
- dly_err  output  1  registered; dly is out of range.

Behaviour:
- Storage: stages 1..MAX_DELAY, each holding {v, d[WIDTH]}. Register dly_q.
- Effective delay: eff = 1 if dly == 0; MAX_DELAY if dly > MAX_DELAY; otherwise dly.
- Reset (async, immediate):
  - all v = 0, all d = 0;
  - dly_q = MAX_DELAY;
  - dly_err = 0;
  - out_valid = 0, dout = 0.
- Every edge, independent of ce:
  - dly_q <= eff;
  - dly_err <= (dly == 0) || (dly > MAX_DELAY).
- Flush: if eff != dly_q at an edge, all stage v bits are cleared at that edge and the input of that cycle is dropped. d contents are don't-care. Flush overrides ce.
- Normal edge (no flush, ce = 1):
  - stage1 <= {in_valid, din ^ inv_mask};
  - stage k <= stage k-1 for k = 2..MAX_DELAY.
- ce = 0, no flush: all stages hold.
- Output, combinational from the tap stage dly_q:
  - out_valid = stage[dly_q].v;
  - dout = stage[dly_q].v ? stage[dly_q].d : 0. dout is forced to 0 when not valid.
- Latency: a word accepted at edge n (ce = 1, in_valid = 1) appears on dout after edge n + dly_q - 1, counting only ce-high edges.
  - dly_q = 1: visible in the cycle immediately after edge n.
- Throughput: one word per ce-high cycle; no backpressure; order preserved.
- Words with in_valid = 0 still occupy a slot; they produce bubbles (out_valid = 0) in sequence.
- Simultaneous flush and in_valid: the input is dropped; out_valid is 0 from that edge until new data traverses.
- rst asserted mid-stream clears everything; first valid output resumes dly_q ce-edges after the first accept following deassertion.
- inv_mask = all ones with MAX_DELAY = 2 and dly = 2 reproduces the legacy NOT-with-delay-2 function, cycle-quantised.

Test Plan:
- Reset, then WIDTH = 4, dly = 2, inv_mask = 4'hF, ce = 1; din = 4'hA valid at edge 1 -> out_valid = 1 and dout = 4'h5 after edge 2. Before that, out_valid = 0 and dout = 0.
- dly = 1, inv_mask = 4'h0; stream din 1, 2, 3 on consecutive edges -> dout 1, 2, 3 on the cycles right after each edge, with no gaps.
- dly = 2; accept 4'h3 at edge 1; hold ce = 0 for 3 edges -> out_valid stays 0. ce back to 1 -> dout = 4'h3 after the next ce-high edge.
- Stream at dly = 2, then change dly to 1 at edge 5 -> all v cleared and the edge-5 input dropped; out_valid = 0. Input at edge 6 appears after edge 6.
- dly = 0 -> dly_err = 1 after the next edge, eff = 1. dly = 3 with MAX_DELAY = 2 -> dly_err = 1, eff = 2. Valid dly -> dly_err = 0 next edge.
- Assert rst asynchronously mid-cycle with 2 words in flight -> out_valid and dout drop to 0 immediately; dly_q = MAX_DELAY; no stale word emerges afterwards.
